srambank_param: RTL and testbench

//  Parametrised synchronous single-port SRAM bank; successor to the fixed 1024x48 bank.

---
 rtl/srambank_pkg.sv | 20 ++
 rtl/srambank_init_seq.sv | 50 +++++
 rtl/srambank_param.sv | 133 +++++++++++++
 tb/tb_srambank_param.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/srambank_pkg.sv
// -----------------------------------------------------------------------------
// srambank_pkg
//   Shared definitions for the parametrised SRAM bank:
//     - init/ready FSM state encodings (legacy-compatible localparam constants)
//     - clog2 helper used to size the internal word index and init counter
// -----------------------------------------------------------------------------
package srambank_pkg;

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  // Ceiling log2; clog2(1) = 0, so callers clamp to at least one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/srambank_init_seq.sv
// -----------------------------------------------------------------------------
// srambank_init_seq
//   Post-reset zero-init sequencer. After reset releases it walks the whole
//   bank for exactly WORDS cycles, requesting a zero write to one word per
//   cycle, then parks in READY.
// Ports
//   clk        in   clock, all logic on posedge
//   reset      in   synchronous, active-high; restarts the sweep at word 0
//   busy       out  high while sweeping (decoded from the state register)
//   init_we    out  zero-write request for init_addr this cycle
//   init_addr  out  word currently being cleared
// -----------------------------------------------------------------------------
module srambank_init_seq
  import srambank_pkg::*;
#(
  parameter int WORDS = 1024,
  parameter int IW    = 10
) (
  input  logic          clk,
  input  logic          reset,
  output logic          busy,
  output logic          init_we,
  output logic [IW-1:0] init_addr
);

  logic [0:0]    state;
  logic [IW-1:0] cnt;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else if (state == ST_INIT) begin
      if (cnt == IW'(WORDS - 1)) begin
        state <= ST_READY;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign busy      = (state == ST_INIT);
  // Suppressed while reset is held so a restart never races the old sweep.
  assign init_we   = busy && !reset;
  assign init_addr = cnt;

endmodule

// File: rtl/srambank_param.sv
// -----------------------------------------------------------------------------
// srambank_param
//   Parametrised synchronous single-port SRAM bank with per-group write mask,
//   registered read data plus read-valid strobe, post-reset zero-init with busy
//   flag, and a sticky error flag for illegal accesses.
// Parameters
//   WORDS  number of words (any value >= 1)
//   BITS   data width, multiple of GRAN
//   GRAN   write-mask granularity; NGRP = BITS/GRAN mask bits
//   AW     address width, 2**AW >= WORDS
// Ports
//   clk      in   clock
//   reset    in   synchronous, active-high
//   ADDRESS  in   word address
//   wd       in   write data
//   wmask    in   group write enables, bit i covers wd[i*GRAN +: GRAN]
//   banksel  in   qualifies every access
//   read     in   read enable
//   write    in   write enable
//   dataout  out  registered read data, held until the next accepted read
//   rvalid   out  one-cycle pulse when dataout updates
//   busy     out  zero-init in progress; accesses ignored
//   err      out  sticky illegal-access flag, cleared only by reset
// Configuration
//   SRAMBANK_OUTREG_EN  adds a second output stage (read latency 2, rvalid
//                       delayed to stay aligned with dataout)
// -----------------------------------------------------------------------------
module srambank_param
  import srambank_pkg::*;
#(
  parameter  int WORDS = 1024,
  parameter  int BITS  = 48,
  parameter  int GRAN  = 8,
  parameter  int AW    = 10,
  localparam int NGRP  = BITS / GRAN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   ADDRESS,
  input  logic [BITS-1:0] wd,
  input  logic [NGRP-1:0] wmask,
  input  logic            banksel,
  input  logic            read,
  input  logic            write,
  output logic [BITS-1:0] dataout,
  output logic            rvalid,
  output logic            busy,
  output logic            err
);

  localparam int IW = (clog2(WORDS) < 1) ? 1 : clog2(WORDS);

  logic [BITS-1:0] mem [WORDS];

  logic            init_we;
  logic [IW-1:0]   init_addr;
  logic [IW-1:0]   idx;
  logic            addr_ok;
  logic            req;
  logic            acc_wr;
  logic            acc_rd;
  logic            illegal;
  logic [BITS-1:0] dout_q;
  logic            rvalid_q;

  srambank_init_seq #(
    .WORDS (WORDS),
    .IW    (IW)
  ) u_init_seq (
    .clk       (clk),
    .reset     (reset),
    .busy      (busy),
    .init_we   (init_we),
    .init_addr (init_addr)
  );

  // Only the low IW bits can address a legal word; higher bits are covered by
  // the range check.
  assign idx     = ADDRESS[IW-1:0];
  assign addr_ok = ({1'b0, ADDRESS} < (AW + 1)'(WORDS));
  assign req     = banksel && (read || write);

  assign acc_wr  = req && !busy && write && addr_ok;
  // A simultaneous write wins; the read half is dropped.
  assign acc_rd  = req && !busy && read && !write && addr_ok;
  assign illegal = req && (busy || !addr_ok || (read && write));

  // NOTE: the array has no reset branch so it maps onto an SRAM macro; the
  // init sequencer clears it one word per cycle instead.
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_addr] <= '0;
    end else if (acc_wr) begin
      for (int g = 0; g < NGRP; g++) begin
        if (wmask[g]) mem[idx][g*GRAN +: GRAN] <= wd[g*GRAN +: GRAN];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q   <= '0;
      rvalid_q <= 1'b0;
      err      <= 1'b0;
    end else begin
      rvalid_q <= acc_rd;
      if (acc_rd)  dout_q <= mem[idx];
      if (illegal) err    <= 1'b1;
    end
  end

`ifdef SRAMBANK_OUTREG_EN
  logic [BITS-1:0] dout_q2;
  logic            rvalid_q2;

  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q2   <= '0;
      rvalid_q2 <= 1'b0;
    end else begin
      dout_q2   <= dout_q;
      rvalid_q2 <= rvalid_q;
    end
  end

  assign dataout = dout_q2;
  assign rvalid  = rvalid_q2;
`else
  assign dataout = dout_q;
  assign rvalid  = rvalid_q;
`endif

endmodule

// File: tb/tb_srambank_param.sv
// -----------------------------------------------------------------------------
// tb_srambank_param
//   Directed bench for srambank_param. Instance A: WORDS=16 (init timing,
//   masked writes, read/write collision, mid-init reset). Instance B:
//   WORDS=1000 (non power-of-2 depth, out-of-range and busy accesses).
//   Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_srambank_param;

`ifdef SRAMBANK_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic [47:0] wd;
  logic [5:0]  wmask;

  logic        reset_a, bs_a, rd_a, wr_a;
  logic [4:0]  addr_a;
  logic [47:0] dout_a;
  logic        rvalid_a, busy_a, err_a;

  logic        reset_b, bs_b, rd_b, wr_b;
  logic [9:0]  addr_b;
  logic [47:0] dout_b;
  logic        rvalid_b, busy_b, err_b;

  int checks;
  int failures;
  int n;

  srambank_param #(.WORDS(16), .BITS(48), .GRAN(8), .AW(5)) dut_a (
    .clk     (clk),
    .reset   (reset_a),
    .ADDRESS (addr_a),
    .wd      (wd),
    .wmask   (wmask),
    .banksel (bs_a),
    .read    (rd_a),
    .write   (wr_a),
    .dataout (dout_a),
    .rvalid  (rvalid_a),
    .busy    (busy_a),
    .err     (err_a)
  );

  srambank_param #(.WORDS(1000), .BITS(48), .GRAN(8), .AW(10)) dut_b (
    .clk     (clk),
    .reset   (reset_b),
    .ADDRESS (addr_b),
    .wd      (wd),
    .wmask   (wmask),
    .banksel (bs_b),
    .read    (rd_b),
    .write   (wr_b),
    .dataout (dout_b),
    .rvalid  (rvalid_b),
    .busy    (busy_b),
    .err     (err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Counts cycles with busy high, starting at the current sample point.
  task automatic count_busy_a(output int cnt);
    cnt = 0;
    while (busy_a && cnt < 2000) begin
      cnt++;
      tick();
    end
  endtask

  task automatic count_busy_b(output int cnt);
    cnt = 0;
    while (busy_b && cnt < 2000) begin
      cnt++;
      tick();
    end
  endtask

  // One-cycle access, then wait until the read result would be visible.
  task automatic access_a(input logic [4:0] a, input logic r, input logic w,
                          input logic [47:0] d, input logic [5:0] m);
    addr_a = a; rd_a = r; wr_a = w; wd = d; wmask = m; bs_a = 1'b1;
    tick();
    bs_a = 1'b0; rd_a = 1'b0; wr_a = 1'b0;
    repeat (LAT - 1) tick();
  endtask

  task automatic access_b(input logic [9:0] a, input logic r, input logic w,
                          input logic [47:0] d, input logic [5:0] m);
    addr_b = a; rd_b = r; wr_b = w; wd = d; wmask = m; bs_b = 1'b1;
    tick();
    bs_b = 1'b0; rd_b = 1'b0; wr_b = 1'b0;
    repeat (LAT - 1) tick();
  endtask

  task automatic read_a(input logic [4:0] a, input logic [47:0] exp, input string tag);
    access_a(a, 1'b1, 1'b0, 48'h0, 6'h0);
    check({tag, "_rvalid"}, 64'(rvalid_a), 64'd1);
    check({tag, "_data"}, 64'(dout_a), 64'(exp));
  endtask

  initial begin
    checks = 0; failures = 0;
    wd = '0; wmask = '0;
    reset_a = 1'b1; bs_a = 1'b0; rd_a = 1'b0; wr_a = 1'b0; addr_a = '0;
    reset_b = 1'b1; bs_b = 1'b0; rd_b = 1'b0; wr_b = 1'b0; addr_b = '0;

    // ---- 1: reset state, init duration, zero-filled array ------------------
    @(negedge clk);
    tick(); tick();
    check("rst_busy", 64'(busy_a), 64'd1);
    check("rst_rvalid", 64'(rvalid_a), 64'd0);
    check("rst_err", 64'(err_a), 64'd0);
    check("rst_dout", 64'(dout_a), 64'd0);
    reset_a = 1'b0;
    count_busy_a(n);
    check("init_cycles_a", 64'(n), 64'd16);
    check("init_err_a", 64'(err_a), 64'd0);
    for (int i = 0; i < 16; i++) read_a(5'(i), 48'h0, $sformatf("zero%0d", i));
    check("zero_err", 64'(err_a), 64'd0);

    // ---- 2: full write then read, rvalid is a single pulse -----------------
    access_a(5'd5, 1'b0, 1'b1, 48'hABCDEF012345, 6'b111111);
    check("wr_no_rvalid", 64'(rvalid_a), 64'd0);
    read_a(5'd5, 48'hABCDEF012345, "full");
    tick();
    check("rvalid_pulse", 64'(rvalid_a), 64'd0);
    check("dout_hold", 64'(dout_a), 64'hABCDEF012345);

    // ---- 3: masked writes; a write never touches dataout -------------------
    access_a(5'd5, 1'b0, 1'b1, 48'hFFFFFFFFFFFF, 6'b000011);
    check("wr_keeps_dout", 64'(dout_a), 64'hABCDEF012345);
    read_a(5'd5, 48'hABCDEF01FFFF, "mask03");
    access_a(5'd5, 1'b0, 1'b1, 48'hFFFFFFFFFFFF, 6'b000100);
    read_a(5'd5, 48'hABCDEFFFFFFF, "mask04");
    access_a(5'd5, 1'b0, 1'b1, 48'h000000000000, 6'b000000);
    read_a(5'd5, 48'hABCDEFFFFFFF, "mask00");
    check("mask_err", 64'(err_a), 64'd0);

    // ---- 4: read+write collision: write lands, read dropped, err sticks ----
    access_a(5'd7, 1'b1, 1'b1, 48'h1, 6'b111111);
    check("rw_no_rvalid", 64'(rvalid_a), 64'd0);
    check("rw_err", 64'(err_a), 64'd1);
    check("rw_dout", 64'(dout_a), 64'hABCDEFFFFFFF);
    read_a(5'd7, 48'h1, "rw_mem");
    repeat (5) tick();
    check("err_sticky", 64'(err_a), 64'd1);

    // ---- 5: WORDS=1000: busy access, last word, out-of-range ---------------
    reset_b = 1'b0;
    check("b_busy", 64'(busy_b), 64'd1);
    check("b_err0", 64'(err_b), 64'd0);
    access_b(10'd3, 1'b1, 1'b0, 48'h0, 6'h0);
    check("busy_rd_rvalid", 64'(rvalid_b), 64'd0);
    check("busy_rd_err", 64'(err_b), 64'd1);
    reset_b = 1'b1;
    tick();
    reset_b = 1'b0;
    check("b_rst_err", 64'(err_b), 64'd0);
    count_busy_b(n);
    check("init_cycles_b", 64'(n), 64'd1000);
    access_b(10'd999, 1'b0, 1'b1, 48'h123456789ABC, 6'b111111);
    access_b(10'd999, 1'b1, 1'b0, 48'h0, 6'h0);
    check("b_last_rvalid", 64'(rvalid_b), 64'd1);
    check("b_last_data", 64'(dout_b), 64'h123456789ABC);
    check("b_last_err", 64'(err_b), 64'd0);
    access_b(10'd1010, 1'b1, 1'b0, 48'h0, 6'h0);
    check("oor_rvalid", 64'(rvalid_b), 64'd0);
    check("oor_dout", 64'(dout_b), 64'h123456789ABC);
    check("oor_err", 64'(err_b), 64'd1);
    access_b(10'd1010, 1'b0, 1'b1, 48'hFFFFFFFFFFFF, 6'b111111);
    access_b(10'd0, 1'b1, 1'b0, 48'h0, 6'h0);
    check("oor_wr_nochg", 64'(dout_b), 64'h0);

    // ---- 6: reset at init count 8 restarts the sweep -----------------------
    reset_a = 1'b1;
    tick();
    reset_a = 1'b0;
    check("rst2_err", 64'(err_a), 64'd0);
    check("rst2_dout", 64'(dout_a), 64'd0);
    repeat (8) tick();
    check("mid_busy", 64'(busy_a), 64'd1);
    reset_a = 1'b1;
    tick();
    reset_a = 1'b0;
    count_busy_a(n);
    check("restart_cycles", 64'(n), 64'd16);
    read_a(5'd7, 48'h0, "reinit7");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "bench time limit reached");
  end

endmodule
